// File: rtl/pulse_in_us_pkg.sv
// Shared types and constants for the pulse width measurement block.
// Also provides the default timeout used by the register-file reset value.
package pulse_in_us_pkg;

   localparam int US_W = 32;

   localparam logic [US_W-1:0] DEFAULT_TIMEOUT = 32'd1_000_000;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_CLEAR = 3'd1;
   localparam logic [2:0] ST_WAIT_START = 3'd2;
   localparam logic [2:0] ST_MEASURE    = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

   typedef enum logic [2:0] {
      IDLE       = ST_IDLE,
      WAIT_CLEAR = ST_WAIT_CLEAR,
      WAIT_START = ST_WAIT_START,
      MEASURE    = ST_MEASURE,
      DONE       = ST_DONE
   } state_t;

   // Modular time difference; the timer wraps, so no special case is needed.
   function automatic logic [US_W-1:0] us_diff(
      input logic [US_W-1:0] a,
      input logic [US_W-1:0] b
   );
      return a - b;
   endfunction

endpackage

// File: rtl/pulse_in_us_sync_ff.sv
// Multi-flop synchronizer for asynchronous pin inputs.
// Chain clears to 0 on reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d_i};
      end
   end

   assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/pulse_in_us.sv
// pulseIn(): measures one HIGH or LOW pulse on pin_i in microseconds.
// Times come from the free-running timer count; outputs are registered.
module pulse_in_us #(
   parameter int                                SYNC_STAGES     = 2,
   parameter logic [pulse_in_us_pkg::US_W-1:0] DEFAULT_TIMEOUT =
      pulse_in_us_pkg::DEFAULT_TIMEOUT
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [pulse_in_us_pkg::US_W-1:0] us_i,
   input  logic                              pin_i,
   input  logic                              start_i,
   input  logic                              level_i,
   input  logic [pulse_in_us_pkg::US_W-1:0] timeout_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic [pulse_in_us_pkg::US_W-1:0] width_o,
   output logic                              timeout_o
);

   import pulse_in_us_pkg::*;

   state_t            r_state;
   logic              r_lvl;
   logic [US_W-1:0]   r_tmo;
   logic [US_W-1:0]   r_t_req;
   logic [US_W-1:0]   r_t_start;

   logic              w_pin_s;
   logic [US_W-1:0]   w_elapsed;
   logic [US_W-1:0]   w_width;
   logic              w_tmo_hit;
   logic              w_match;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (pin_i),
      .q_o   (w_pin_s)
   );

   assign w_elapsed = us_diff(us_i, r_t_req);
   assign w_width   = us_diff(us_i, r_t_start);
   assign w_tmo_hit = (w_elapsed >= r_tmo);
   assign w_match   = (w_pin_s == r_lvl);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_lvl     <= 1'b0;
         r_tmo     <= '0;
         r_t_req   <= '0;
         r_t_start <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         width_o   <= '0;
         timeout_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_lvl   <= level_i;
                  r_tmo   <= (timeout_i != '0) ? timeout_i : DEFAULT_TIMEOUT;
                  r_t_req <= us_i;
                  busy_o  <= 1'b1;
                  r_state <= (w_pin_s == level_i) ? WAIT_CLEAR : WAIT_START;
               end
            end
            WAIT_CLEAR: begin
               if (w_tmo_hit) begin
                  width_o   <= '0;
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  r_state   <= DONE;
               end else if (!w_match) begin
                  r_state <= WAIT_START;
               end
            end
            WAIT_START: begin
               if (w_tmo_hit) begin
                  width_o   <= '0;
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  r_state   <= DONE;
               end else if (w_match) begin
                  r_t_start <= us_i;
                  r_state   <= MEASURE;
               end
            end
            MEASURE: begin
               // A trailing edge in the timeout cycle still reports a width.
               if (!w_match) begin
                  width_o   <= w_width;
                  timeout_o <= 1'b0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  r_state   <= DONE;
               end else if (w_tmo_hit) begin
                  width_o   <= '0;
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               busy_o  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_in_us.sv
// Directed scoreboard bench for pulse_in_us; one timer tick per clock
// unless the tick is frozen to model sub-microsecond pulses.
module tb_pulse_in_us;

   typedef struct {
      logic [31:0] width;
      logic        tmo;
      logic [31:0] done_us;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] us_i = '0;
   logic        pin_i = 1'b0;
   logic        start_i = 1'b0;
   logic        level_i = 1'b0;
   logic [31:0] timeout_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] width_o;
   logic        timeout_o;

   int   checks = 0;
   int   failures = 0;
   bit   us_run = 1'b1;
   exp_t sb[$];

   pulse_in_us #(
      .SYNC_STAGES     (2),
      .DEFAULT_TIMEOUT (32'd1_000_000)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .us_i      (us_i),
      .pin_i     (pin_i),
      .start_i   (start_i),
      .level_i   (level_i),
      .timeout_i (timeout_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .width_o   (width_o),
      .timeout_o (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every done_o must match the oldest expectation.
   always @(posedge clk_i) begin
      #1;
      if (done_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("width", width_o, e.width);
            chk("timeout_flag", {31'd0, timeout_o}, {31'd0, e.tmo});
            chk("done_us", us_i, e.done_us);
            chk("busy_at_done", {31'd0, busy_o}, 32'd0);
         end
      end
   end

   task automatic cyc();
      @(negedge clk_i);
      if (us_run) us_i = us_i + 32'd1;
   endtask

   task automatic run_to(input logic [31:0] t);
      while (us_i != t) cyc();
   endtask

   task automatic start(input logic lvl, input logic [31:0] tmo);
      start_i   = 1'b1;
      level_i   = lvl;
      timeout_i = tmo;
      cyc();
      start_i   = 1'b0;
      chk("busy_after_start", {31'd0, busy_o}, 32'd1);
   endtask

   task automatic expect_done(input logic [31:0] w, input logic t,
                              input logic [31:0] at);
      exp_t e;
      e.width   = w;
      e.tmo     = t;
      e.done_us = at;
      sb.push_back(e);
   endtask

   // Bounded wait for done_o; optionally strobe start_i in the DONE cycle.
   task automatic wait_done(input int budget, input bit poke);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cyc();
         if (done_o === 1'b1) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         failures++;
         $error("FAIL done_wait observed=0 expected=1");
      end
      if (seen && poke) begin
         start_i   = 1'b1;
         level_i   = 1'b1;
         timeout_i = 32'd5;
      end
      cyc();
      start_i = 1'b0;
      cyc();
      chk("sb_empty", sb.size(), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) cyc();
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_width", width_o, 32'd0);
      chk("rst_tmo", {31'd0, timeout_o}, 32'd0);
      rst_i = 1'b0;
      run_to(32'd10);

      // 1: HIGH pulse 100..350, extra start while busy ignored
      start(1'b1, 32'd0);
      run_to(32'd100);
      pin_i = 1'b1;
      run_to(32'd200);
      start_i   = 1'b1;
      level_i   = 1'b0;
      timeout_i = 32'd1;
      cyc();
      start_i = 1'b0;
      chk("busy_ignored_start", {31'd0, busy_o}, 32'd1);
      run_to(32'd350);
      pin_i = 1'b0;
      expect_done(32'd250, 1'b0, 32'd352);
      wait_done(50, 1'b0);

      // 2: pin already high at start, partial pulse skipped; start in DONE
      run_to(32'd400);
      pin_i = 1'b1;
      run_to(32'd410);
      start(1'b1, 32'd0);
      run_to(32'd450);
      pin_i = 1'b0;
      run_to(32'd460);
      pin_i = 1'b1;
      run_to(32'd490);
      pin_i = 1'b0;
      expect_done(32'd30, 1'b0, 32'd492);
      wait_done(200, 1'b1);
      repeat (10) cyc();
      chk("busy_after_done_poke", {31'd0, busy_o}, 32'd0);

      // 3: LOW pulse never comes, timeout at exactly 500 us
      run_to(32'd600);
      pin_i = 1'b1;
      run_to(32'd1000);
      start(1'b0, 32'd500);
      expect_done(32'd0, 1'b1, 32'd1500);
      wait_done(700, 1'b0);

      // 4: pulse straddling the timer wrap
      us_i = 32'hFFFF_FE00;
      pin_i = 1'b0;
      run_to(32'hFFFF_FE10);
      start(1'b1, 32'd0);
      run_to(32'hFFFF_FF00);
      pin_i = 1'b1;
      run_to(32'h0000_0064);
      pin_i = 1'b0;
      expect_done(32'd356, 1'b0, 32'h0000_0066);
      wait_done(50, 1'b0);

      // 5: reset during MEASURE aborts silently
      run_to(32'h100);
      start(1'b1, 32'd0);
      run_to(32'h110);
      pin_i = 1'b1;
      run_to(32'h120);
      chk("busy_in_measure", {31'd0, busy_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_width", width_o, 32'd0);
      chk("mid_rst_tmo", {31'd0, timeout_o}, 32'd0);
      cyc();
      rst_i = 1'b0;
      pin_i = 1'b0;
      repeat (20) cyc();
      chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("post_rst_sb", sb.size(), 32'd0);

      // 6a: one-clock glitch with a frozen timer gives width 0
      run_to(32'h200);
      start(1'b1, 32'd0);
      run_to(32'h210);
      us_run = 1'b0;
      pin_i = 1'b1;
      cyc();
      pin_i = 1'b0;
      expect_done(32'd0, 1'b0, 32'h210);
      wait_done(20, 1'b0);
      us_run = 1'b1;

      // 6b: trailing edge in the same cycle as the timeout
      run_to(32'd5000);
      start(1'b1, 32'd40);
      run_to(32'd5010);
      pin_i = 1'b1;
      run_to(32'd5038);
      pin_i = 1'b0;
      expect_done(32'd28, 1'b0, 32'd5040);
      wait_done(50, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
